// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: valid/ready stage register with a one-entry skid, sync flush and enable freeze
module pipe_stage_buffer #(
  parameter int NB_DATA       = 85,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en_pipeline,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [NB_DATA-1:0] in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [NB_DATA-1:0] out_data_o,
  output logic [1:0]         count_o
);
  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic [NB_DATA-1:0] main_data_q, main_data_d;
  logic [NB_DATA-1:0] skid_data_q, skid_data_d;
  logic               acc, drn, pop;
  assign in_ready_o  = en_pipeline & ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = (ZERO_ON_EMPTY && !main_valid_q) ? '0 : main_data_q;
  assign count_o     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign acc         = in_valid_i & in_ready_o;
  assign drn         = main_valid_q & out_ready_i & en_pipeline;
  // main slot reloads when it is empty or its beat leaves on this edge; skid (older) wins over input
  assign pop         = ~main_valid_q | drn;
  always_comb begin
    main_valid_d = pop ? (skid_valid_q | acc) : main_valid_q;
    main_data_d  = (pop && skid_valid_q) ? skid_data_q : (pop && acc) ? in_data_i : main_data_q;
    skid_valid_d = skid_valid_q ? ~drn : (acc & ~pop);
    skid_data_d  = (!skid_valid_q && acc && !pop) ? in_data_i : skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end
  end
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: queue-model checker plus directed literal checks for pipe_stage_buffer
module tb_pipe_stage_buffer;
  localparam int NB = 85;
  logic          clock = 1'b0;
  logic          reset;
  logic          en_pipeline, flush_i, in_valid_i, out_ready_i;
  logic [NB-1:0] in_data_i;
  logic          in_ready_o, out_valid_o, in_ready_1, out_valid_1;
  logic [NB-1:0] out_data_o, out_data_1;
  logic [1:0]    count_o, count_1;
  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0] mq[$];
  logic [NB-1:0] held;
  logic [95:0]   rnd;

  pipe_stage_buffer #(.NB_DATA(NB), .ZERO_ON_EMPTY(1'b1)) dut (
    .clock(clock), .reset(reset), .en_pipeline(en_pipeline), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .count_o(count_o));

  pipe_stage_buffer #(.NB_DATA(NB), .ZERO_ON_EMPTY(1'b0)) dut_nz (
    .clock(clock), .reset(reset), .en_pipeline(en_pipeline), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_1), .in_data_i(in_data_i),
    .out_valid_o(out_valid_1), .out_ready_i(out_ready_i), .out_data_o(out_data_1), .count_o(count_1));

  always #10 clock = ~clock;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: the stage is a FIFO of depth 2 whose head is the output
  always @(negedge reset) begin
    mq.delete();
    held = '0;
  end

  always @(negedge clock) begin
    if (reset) begin
      bit acc, drn;
      acc = in_valid_i && en_pipeline && mq.size() < 2;
      drn = mq.size() > 0 && out_ready_i && en_pipeline;
      if (flush_i) begin
        mq.delete();
        held = '0;
      end else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(in_data_i);
        if (mq.size() > 0) held = mq[0];
      end
    end
  end

  always @(posedge clock) begin
    chk("out_valid", {{(NB-1){1'b0}}, out_valid_o}, {{(NB-1){1'b0}}, mq.size() > 0});
    chk("count", {{(NB-2){1'b0}}, count_o}, NB'(mq.size()));
    chk("in_ready", {{(NB-1){1'b0}}, in_ready_o}, {{(NB-1){1'b0}}, en_pipeline && mq.size() < 2});
    chk("out_data", out_data_o, mq.size() > 0 ? mq[0] : '0);
    chk("nz_out_data", out_data_1, mq.size() > 0 ? mq[0] : held);
    chk("nz_count", {{(NB-2){1'b0}}, count_1}, NB'(mq.size()));
  end

  task automatic step(input logic v, input logic [NB-1:0] d, input logic r, input logic e, input logic f);
    in_valid_i = v; in_data_i = d; out_ready_i = r; en_pipeline = e; flush_i = f;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; en_pipeline = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
    #2 reset = 1'b0;
    #2;
    chk("rst_count", NB'(count_o), NB'(0));
    chk("rst_valid", NB'(out_valid_o), NB'(0));
    chk("rst_data", out_data_o, '0);
    chk("rst_ready", NB'(in_ready_o), NB'(1));
    @(posedge clock);
    #1 reset = 1'b1;
    step(1'b1, NB'('hA5), 1'b0, 1'b1, 1'b0);
    chk("a5_data", out_data_o, NB'('hA5));
    chk("a5_count", NB'(count_o), NB'(1));
    step(1'b1, NB'('hB0), 1'b0, 1'b1, 1'b0);
    chk("full_count", NB'(count_o), NB'(2));
    chk("full_ready", NB'(in_ready_o), NB'(0));
    in_valid_i = 1'b0;
    #3 reset = 1'b0;
    #2;
    chk("mid_rst_count", NB'(count_o), NB'(0));
    chk("mid_rst_valid", NB'(out_valid_o), NB'(0));
    chk("mid_rst_data", out_data_o, '0);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, NB'(i), 1'b1, 1'b1, 1'b0);
      chk("stream_data", out_data_o, NB'(i));
      chk("stream_count", NB'(count_o), NB'(1));
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, NB'('h20), 1'b0, 1'b1, 1'b0);
    chk("bp_head0", out_data_o, NB'('h20));
    step(1'b1, NB'('h21), 1'b0, 1'b1, 1'b0);
    chk("bp_count2", NB'(count_o), NB'(2));
    step(1'b1, NB'('h22), 1'b0, 1'b1, 1'b0);
    chk("bp_hold_count", NB'(count_o), NB'(2));
    chk("bp_ready", NB'(in_ready_o), NB'(0));
    chk("bp_hold_head", out_data_o, NB'('h20));
    step(1'b1, NB'('h22), 1'b1, 1'b1, 1'b0);
    chk("bp_head1", out_data_o, NB'('h21));
    chk("bp_ready_back", NB'(in_ready_o), NB'(1));
    step(1'b1, NB'('h22), 1'b1, 1'b1, 1'b0);
    chk("bp_head2", out_data_o, NB'('h22));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("bp_empty", NB'(count_o), NB'(0));
    step(1'b1, NB'('h30), 1'b0, 1'b1, 1'b0);
    step(1'b1, NB'('h31), 1'b0, 1'b1, 1'b0);
    step(1'b1, NB'('h33), 1'b1, 1'b1, 1'b1);
    chk("flush_count", NB'(count_o), NB'(0));
    chk("flush_valid", NB'(out_valid_o), NB'(0));
    chk("flush_data", out_data_o, '0);
    chk("flush_nz_data", out_data_1, '0);
    step(1'b1, NB'('h40), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, NB'('h41), 1'b1, 1'b0, 1'b0);
      chk("frz_count", NB'(count_o), NB'(1));
      chk("frz_data", out_data_o, NB'('h40));
      chk("frz_ready", NB'(in_ready_o), NB'(0));
    end
    step(1'b1, NB'('h41), 1'b1, 1'b1, 1'b0);
    chk("frz_resume", out_data_o, NB'('h41));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, NB'('h5A), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("nz_valid", NB'(out_valid_1), NB'(0));
    chk("nz_held", out_data_1, NB'('h5A));
    chk("z_zero", out_data_o, '0);
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), rnd[NB-1:0], 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
